// File: rtl/hypot_req_sched_if.sv
// Requester-side bundle for hypot_req_sched: operand requests in, per-requester responses out.
// A transfer happens on a rising clk edge where valid and ready are both high; valid never waits on ready.
interface hypot_req_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_x;
    logic [NUM_REQ*DATA_W-1:0] req_y;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/hypot_req_sched.sv
// Round-robin scheduler sharing one iterative hypot engine between NUM_REQ requesters, with a completion watchdog.
// Optional statistics counters are built when HYPOT_SCHED_STATS_EN is defined.
module hypot_req_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    hypot_req_sched_if.slave  bus,
    output logic              eng_start,
    output logic [DATA_W-1:0] eng_x,
    output logic [DATA_W-1:0] eng_y,
    output logic              eng_abort,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_result,
    output logic [15:0]       stat_ops,
    output logic [7:0]        stat_tmo,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]  eng_x_q, eng_x_d, eng_y_q, eng_y_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] req_ready_c;
    logic               found;
    logic [PTR_W-1:0]   gnt_idx;

    // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_W:0] sum;
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
            if (!found && bus.req_valid[sum[PTR_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        wait_cnt_d  = wait_cnt_q;
        eng_x_d     = eng_x_q;
        eng_y_d     = eng_y_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_c = '0;
        eng_start   = 1'b0;
        eng_abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready_c = NUM_REQ'(1) << gnt_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (PTR_W'(i) == gnt_idx) begin
                            eng_x_d = bus.req_x[i*DATA_W +: DATA_W];
                            eng_y_d = bus.req_y[i*DATA_W +: DATA_W];
                        end
                    end
                    gnt_d   = gnt_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start  = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the last watchdog cycle still counts as a normal result.
                if (eng_done) begin
                    rsp_data_d  = eng_result;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    state_d     = S_RESP;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
                    eng_abort   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (gnt_q == PTR_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            wait_cnt_q  <= '0;
            eng_x_q     <= '0;
            eng_y_q     <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            wait_cnt_q  <= wait_cnt_d;
            eng_x_q     <= eng_x_d;
            eng_y_q     <= eng_y_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign eng_x         = eng_x_q;
    assign eng_y         = eng_y_q;
    assign dbg_state     = state_q;

`ifdef HYPOT_SCHED_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [7:0]  stat_tmo_q, stat_tmo_d;

    // Saturating counters: they stick at all-ones rather than wrap.
    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_tmo_d = stat_tmo_q;
        if (state_q == S_RESP && bus.rsp_ready[gnt_q] && !rsp_err_q && stat_ops_q != '1)
            stat_ops_d = stat_ops_q + 1'b1;
        if (eng_abort && stat_tmo_q != '1)
            stat_tmo_d = stat_tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q <= '0;
            stat_tmo_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_tmo_q <= stat_tmo_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_tmo = stat_tmo_q;
`else
    assign stat_ops = '0;
    assign stat_tmo = '0;
`endif
endmodule

// File: tb/tb_hypot_req_sched.sv
// Scoreboard bench for hypot_req_sched: directed requests, behavioural engine, monitor popping an expected queue.
module tb_hypot_req_sched;
    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam int W           = 1 + 3 + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hypot_req_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    logic              eng_start, eng_abort, eng_done;
    logic [DATA_W-1:0] eng_x, eng_y, eng_result;
    logic [15:0]       stat_ops;
    logic [7:0]        stat_tmo;
    logic [1:0]        dbg_state;

    hypot_req_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_abort  (eng_abort),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .stat_ops   (stat_ops),
        .stat_tmo   (stat_tmo),
        .dbg_state  (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int gnt_log[$];
    int cyc = 0;
    int start_cyc, abort_cyc, acc_cyc, rsp_cyc;
    int abort_cnt = 0;
    logic [DATA_W-1:0]  st_x, st_y;
    logic [NUM_REQ-1:0] prev_rsp_valid = '0;
    int eng_lat = 3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [2:0] oh2idx(input logic [NUM_REQ-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // ---------------- engine model ----------------
    initial begin
        int cd;
        int ex, ey;
        cd = -1;
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (!rst_n) cd = -1;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_done   = 1'b1;
                    eng_result = DATA_W'(isqrt(ex * ex + ey * ey));
                    cd         = -1;
                end
            end
            if (rst_n && eng_start && eng_lat > 0) begin
                cd = eng_lat;
                ex = int'(eng_x);
                ey = int'(eng_y);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_ready != '0) begin
                check("req_ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                gnt_log.push_back(int'(oh2idx(bus.req_ready)));
                acc_cyc = cyc;
            end
            if (eng_start) begin
                start_cyc = cyc;
                st_x = eng_x;
                st_y = eng_y;
            end
            if (eng_abort) begin
                abort_cyc = cyc;
                abort_cnt++;
            end
            if (bus.rsp_valid != '0 && prev_rsp_valid == '0) rsp_cyc = cyc;
            if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
                check("rsp_valid_onehot", 32'($onehot(bus.rsp_valid)), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got data %0d err %0d with empty queue", bus.rsp_data, bus.rsp_err);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("rsp_err_idx_data", 32'({bus.rsp_err, oh2idx(bus.rsp_valid), bus.rsp_data}), 32'(e));
                end
            end
        end
        prev_rsp_valid = bus.rsp_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int i, input int x, input int y, input bit push,
                         input int exp_data, input bit exp_err);
        int n;
        if (push) exp_q.push_back({exp_err, 3'(i), DATA_W'(exp_data)});
        bus.req_x[i*DATA_W +: DATA_W] = DATA_W'(x);
        bus.req_y[i*DATA_W +: DATA_W] = DATA_W'(y);
        bus.req_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready[i] && n < 200);
        if (!bus.req_ready[i]) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dbg_state != 2'd0 || bus.rsp_valid != '0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input int x, input int y);
        bus.req_x[i*DATA_W +: DATA_W] = DATA_W'(x);
        bus.req_y[i*DATA_W +: DATA_W] = DATA_W'(y);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({tag, "_eng_start"}, 32'(eng_start),     32'd0);
        check({tag, "_eng_abort"}, 32'(eng_abort),     32'd0);
        check({tag, "_eng_x"},     32'(eng_x),         32'd0);
        check({tag, "_eng_y"},     32'(eng_y),         32'd0);
        check({tag, "_stat_ops"},  32'(stat_ops),      32'd0);
        check({tag, "_stat_tmo"},  32'(stat_tmo),      32'd0);
        check({tag, "_state"},     32'(dbg_state),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int ab0, n;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = '1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request 3,4 -> 5, engine answers 3 cycles after start.
        eng_lat = 3;
        issue(0, 3, 4, 1'b1, 5, 1'b0);
        wait_idle();
        check("single_grants", 32'(gnt_log.size()), 32'd1);
        if (gnt_log.size() > 0) check("single_gnt_idx", 32'(gnt_log[0]), 32'd0);
        check("single_eng_x", 32'(st_x), 32'd3);
        check("single_eng_y", 32'(st_y), 32'd4);
        check("single_start_lat", 32'(start_cyc - acc_cyc), 32'd1);
        check("single_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd5);

        // Best case latency: done on first WAIT cycle.
        eng_lat = 1;
        issue(1, 6, 8, 1'b1, 10, 1'b0);
        wait_idle();
        check("best_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd3);

        // Watchdog expiry.
        eng_lat = -1;
        ab0 = abort_cnt;
        issue(2, 7, 24, 1'b1, 0, 1'b1);
        wait_idle();
        check("tmo_abort_count", 32'(abort_cnt - ab0), 32'd1);
        check("tmo_abort_cycle", 32'(abort_cyc - start_cyc), 32'd64);
        check("tmo_rsp_after_abort", 32'(rsp_cyc - abort_cyc), 32'd1);
`ifdef HYPOT_SCHED_STATS_EN
        check("tmo_stat_tmo", 32'(stat_tmo), 32'd1);
`else
        check("tmo_stat_tmo", 32'(stat_tmo), 32'd0);
`endif

        // Done arrives on the final WAIT cycle: no abort.
        eng_lat = 64;
        ab0 = abort_cnt;
        issue(3, 5, 12, 1'b1, 13, 1'b0);
        wait_idle();
        check("collide_no_abort", 32'(abort_cnt - ab0), 32'd0);
        check("collide_rsp_cycle", 32'(rsp_cyc - start_cyc), 32'd65);
`ifdef HYPOT_SCHED_STATS_EN
        check("stat_ops_after_4", 32'(stat_ops), 32'd3);
`else
        check("stat_ops_after_4", 32'(stat_ops), 32'd0);
`endif

        // Round robin with all requesters held valid.
        apply_reset();
        gnt_log.delete();
        eng_lat = 2;
        set_req(0, 3, 4);
        set_req(1, 6, 8);
        set_req(2, 8, 15);
        set_req(3, 20, 21);
        exp_q.push_back({1'b0, 3'd0, 8'd5});
        exp_q.push_back({1'b0, 3'd1, 8'd10});
        exp_q.push_back({1'b0, 3'd2, 8'd17});
        exp_q.push_back({1'b0, 3'd3, 8'd29});
        exp_q.push_back({1'b0, 3'd0, 8'd5});
        exp_q.push_back({1'b0, 3'd1, 8'd10});
        bus.req_valid = '1;
        n = 0;
        while (gnt_log.size() < 6 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_idle();
        check("rr_grant_count", 32'(gnt_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++)
            check("rr_grant_order", 32'(gnt_log[k]), 32'(k % NUM_REQ));

        // Backpressure on requester 2 while requester 0 waits.
        apply_reset();
        gnt_log.delete();
        eng_lat = 2;
        bus.rsp_ready[2] = 1'b0;
        issue(2, 8, 15, 1'b1, 17, 1'b0);
        n = 0;
        while (!bus.rsp_valid[2] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid_seen", 32'(bus.rsp_valid[2]), 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 3'd0, 8'd10});
        set_req(0, 6, 8);
        bus.req_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h4);
            check("bp_rsp_data", 32'(bus.rsp_data), 32'd17);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.rsp_ready[2] = 1'b1;
        n = 0;
        while (gnt_log.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        wait_idle();
        check("bp_grant_count", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() > 1) check("bp_next_grant", 32'(gnt_log[1]), 32'd0);

        // Reset while the engine is busy.
        eng_lat = -1;
        ab0 = abort_cnt;
        issue(1, 9, 12, 1'b0, 0, 1'b0);
        n = 0;
        while (dbg_state != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midwait_in_wait", 32'(dbg_state), 32'd2);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midwait");
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midwait_no_abort", 32'(abort_cnt - ab0), 32'd0);
        gnt_log.delete();
        eng_lat = 2;
        set_req(0, 3, 4);
        set_req(1, 6, 8);
        set_req(2, 8, 15);
        set_req(3, 20, 21);
        exp_q.push_back({1'b0, 3'd0, 8'd5});
        bus.req_valid = '1;
        n = 0;
        while (gnt_log.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_idle();
        check("midwait_grant_count", 32'(gnt_log.size()), 32'd1);
        if (gnt_log.size() > 0) check("midwait_rr_ptr0", 32'(gnt_log[0]), 32'd0);
`ifdef HYPOT_SCHED_STATS_EN
        check("final_stat_ops", 32'(stat_ops), 32'd1);
`else
        check("final_stat_ops", 32'(stat_ops), 32'd0);
`endif
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
